uart_tx_drain: RTL
==================

# uart_tx_drain

UART transmit engine that is the reading end of the transmit-side byte FIFO. It pops one word at a time from a first-word-fall-through FIFO and serializes it LSB-first onto the `tx` line as start, data, optional parity and stop bits. It sits between the TX FIFO and the board pin, and is paced by the shared 16x-oversample baud tick that also drives the receiver.

## Interface
- `DATA_BITS`, default 8: data bits per frame.
- `SB_TICK`, default 16: baud ticks in the stop period. 16 gives 1 stop bit; 32 gives 2 stop bits.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `baud_tick` input, 1 bit: one-`clk` pulse at 16x the baud rate.
- `tx_en` input, 1 bit: permits starting a new frame. A frame already in flight always completes.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_data` input, `DATA_BITS` wide: FIFO head word, valid whenever `fifo_empty` is low.
- `fifo_rd` output, 1 bit: one-cycle pop strobe to the FIFO.
- `tx` output, 1 bit: serial line, registered, idles high.
- `tx_busy` output, 1 bit: high in every state except IDLE.
- `tx_done_tick` output, 1 bit: one-cycle pulse at the end of the stop period.

## Operation
- States and transitions:
  - IDLE → START when `tx_en & ~fifo_empty`.
  - START → DATA.
  - DATA → PARITY if enabled, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- IDLE:
  - `fifo_rd` is asserted combinationally in the same cycle the IDLE → START condition holds.
  - At that same edge `fifo_data` is captured into the shift register and the state moves to START.
  - `fifo_rd` is never high outside IDLE, so the block can never issue two pops per frame.
- Tick counter `s` is 5 bits.
  - It is cleared on every state entry and increments only on `baud_tick`.
  - START, DATA and PARITY each hold for 16 ticks. The state advances on the cycle where `baud_tick & s==15`.
  - STOP holds for `SB_TICK` ticks and exits on `baud_tick & s==SB_TICK-1`.
- Bit counter `n` is `$clog2(DATA_BITS)` bits wide.
  - On each bit boundary in DATA the shift register shifts right and `n` increments.
  - DATA exits when `n==DATA_BITS-1` at a bit boundary.
- `tx` register values by state:
  - 0 in START.
  - Shift register bit 0 in DATA.
  - Parity bit in PARITY.
  - 1 in STOP and IDLE.
- `tx_done_tick` is asserted on the STOP → IDLE transition cycle.
- Back-to-back frames:
  - After STOP, the block spends exactly one `clk` in IDLE.
  - It pops in that cycle if data is available.
  - The resulting inter-frame gap is one `clk` cycle, not one baud period.
- `tx_en` falling mid-frame has no effect until the state returns to IDLE.

## Timing
- Reset values: state IDLE, `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0, counters 0.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously and the frame is abandoned. The word already popped is lost and is not re-read.
- Latency from the `fifo_rd` cycle to `tx` falling is 1 `clk`.
- Frame length in baud ticks is 16·(1+DATA_BITS[+1]) + SB_TICK.
  - The "[+1]" term counts the parity bit and applies only when `UART_TX_PARITY_EN` is defined.
  - With defaults and no parity this is 160 ticks.
- `fifo_data` is sampled only in the `fifo_rd` cycle. Later changes to the FIFO head do not affect the frame in flight.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - The parity bit is even parity: XOR-reduction of the captured word, stored at capture time.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state, the parity register and its logic are absent.
  - DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding, a 3-bit typedef with IDLE/START/DATA/PARITY/STOP;
  - the `OVERSAMPLE = 16` constant, shared with the receiver.
- No sub-module is needed.
  - The tick counter and bit counter are inline.
  - The baud tick generator is external and shared.

## Test plan
- Reset: hold `reset` with `fifo_empty`=0.
  - Required: `tx`=1, `fifo_rd`=0, `tx_busy`=0 throughout.
  - Release `reset` with `tx_en`=0: still no `fifo_rd`.
- Single frame, `baud_tick` high every cycle, no parity, `fifo_data`=0xA5:
  - Exactly one `fifo_rd` pulse.
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - `tx_done_tick` fires 160 cycles after `tx` falls.
- Back-to-back frames with FIFO holding 0x01 then 0xFF:
  - Two `fifo_rd` pulses, 161 cycles apart.
  - The second start bit begins one `clk` after the first stop period ends.
- Parity (`UART_TX_PARITY_EN` defined) with `fifo_data`=0x07:
  - The parity bit is 1.
  - The frame is 176 cycles.
  - With 0x03 the parity bit is 0.
- Mid-frame reset during DATA bit 3:
  - `tx`=1 immediately and the state is IDLE.
  - After release, the next FIFO word is transmitted and the aborted word is not resent.
- `tx_en` dropped during DATA:
  - The current frame completes normally.
  - No further `fifo_rd` occurs while `tx_en`=0, even with `fifo_empty`=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmit and receive engines:
//                the transmit state encoding and the oversample ratio.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Baud ticks per bit period; the receiver samples with the same ratio.
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_drain
//  Description : UART transmitter that drains a first-word-fall-through FIFO.
//                Pops one word in IDLE, then sends start, LSB-first data,
//                optional even parity and stop bits on a registered tx line,
//                paced by a shared 16x baud tick.
//  Options     : define UART_TX_PARITY_EN to insert an even parity bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [4:0]    S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [4:0]           s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // State, counters, shift register and the tx line; reset forces tx idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word is latched when it is popped, not recomputed later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Next-state logic; tx_d is the value tx must take in the state being entered.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = tx_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Gating with reset keeps the pop strobe quiet while reset is held.
        if (tx_en && !fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          state_d = START;
          s_d     = '0;
          n_d     = '0;
          b_d     = fifo_data;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            n_d = n_q + NW'(1);
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d      = IDLE;
            s_d          = '0;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
`default_nettype wire
